// File: rtl/mdu_unit_if.sv
// Request/response bundle between the execute stage and the multiply/divide unit.
interface mdu_unit_if #(
    parameter int WIDTH = 32
);
    logic             Start;
    logic [2:0]       Op;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Busy;
    logic             Done;
    logic [WIDTH-1:0] HI;
    logic [WIDTH-1:0] LO;

    modport master (output Start, Op, A, B, input Busy, Done, HI, LO);
    modport slave  (input Start, Op, A, B, output Busy, Done, HI, LO);
endinterface

// File: rtl/mdu_unit.sv
// Iterative-latency multiply/divide unit owning HI/LO.
// Define MDU_MADD_EN to enable MADD/MADDU accumulate; otherwise those opcodes are no-ops.
module mdu_unit #(
    parameter int WIDTH       = 32,
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic       Clk,
    input  logic       Reset,
    mdu_unit_if.slave  bus
);
`ifdef MDU_MADD_EN
    localparam bit MADD_EN = 1'b1;
`else
    localparam bit MADD_EN = 1'b0;
`endif

    localparam int MAX_CYCLES = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
    localparam int CNT_W      = $clog2(MAX_CYCLES + 1);

    localparam logic [2:0] OP_MULT  = 3'b000;
    localparam logic [2:0] OP_MULTU = 3'b001;
    localparam logic [2:0] OP_DIV   = 3'b010;
    localparam logic [2:0] OP_DIVU  = 3'b011;
    localparam logic [2:0] OP_MTHI  = 3'b100;
    localparam logic [2:0] OP_MTLO  = 3'b101;
    localparam logic [2:0] OP_MADD  = 3'b110;
    localparam logic [2:0] OP_MADDU = 3'b111;

    typedef enum logic [1:0] {IDLE, MUL, DIV} state_t;

    state_t                 state_q, state_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d;
    logic                   accept, finish, wr_mthi, wr_mtlo, wr_en;
    logic [2:0]             op_p0;
    logic [WIDTH-1:0]       a_p0, b_p0;
    logic [WIDTH-1:0]       hi_q, lo_q;
    logic                   done_q;
    logic [2*WIDTH-1:0]     prod, quot, res;

    // Full-width product; sign-extending to 2*WIDTH makes the low 2*WIDTH bits exact
    // for both signed and unsigned operands.
    function automatic logic [2*WIDTH-1:0] mul_full(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b,
                                                     input logic is_signed);
        logic signed [2*WIDTH-1:0] ea, eb, p;
        ea = is_signed ? $signed({{WIDTH{a[WIDTH-1]}}, a}) : $signed({{WIDTH{1'b0}}, a});
        eb = is_signed ? $signed({{WIDTH{b[WIDTH-1]}}, b}) : $signed({{WIDTH{1'b0}}, b});
        p  = ea * eb;
        return p;
    endfunction

    // Returns {remainder, quotient}; MIN/-1 wraps instead of overflowing.
    function automatic logic [2*WIDTH-1:0] div_full(input logic [WIDTH-1:0] a,
                                                     input logic [WIDTH-1:0] b,
                                                     input logic is_signed);
        logic signed [WIDTH-1:0] sa, sb, q, r;
        sa = $signed(a);
        sb = $signed(b);
        if (b == '0) begin
            return '0;
        end else if (is_signed) begin
            if (a == {1'b1, {(WIDTH-1){1'b0}}} && b == {WIDTH{1'b1}}) begin
                q = sa;
                r = '0;
            end else begin
                q = sa / sb;
                r = sa % sb;
            end
            return {r, q};
        end else begin
            return {a % b, a / b};
        end
    endfunction

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        accept  = 1'b0;
        finish  = 1'b0;
        wr_mthi = 1'b0;
        wr_mtlo = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.Start) begin
                    case (bus.Op)
                        OP_MULT, OP_MULTU: begin
                            state_d = MUL;
                            cnt_d   = CNT_W'(MULT_CYCLES);
                            accept  = 1'b1;
                        end
                        OP_DIV, OP_DIVU: begin
                            state_d = DIV;
                            cnt_d   = CNT_W'(DIV_CYCLES);
                            accept  = 1'b1;
                        end
                        OP_MTHI: wr_mthi = 1'b1;
                        OP_MTLO: wr_mtlo = 1'b1;
                        OP_MADD, OP_MADDU: begin
                            if (MADD_EN) begin
                                state_d = MUL;
                                cnt_d   = CNT_W'(MULT_CYCLES);
                                accept  = 1'b1;
                            end
                        end
                        default: ;
                    endcase
                end
            end
            MUL, DIV: begin
                cnt_d = cnt_q - CNT_W'(1);
                if (cnt_q == CNT_W'(1)) begin
                    finish  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Stage p0: operands frozen at Start so later forwarding changes cannot leak in.
    always_ff @(posedge Clk) begin
        if (accept) begin
            op_p0 <= bus.Op;
            a_p0  <= bus.A;
            b_p0  <= bus.B;
        end
    end

    always_comb begin
        prod  = mul_full(a_p0, b_p0, ~op_p0[0]);
        quot  = div_full(a_p0, b_p0, ~op_p0[0]);
        res   = prod;
        wr_en = 1'b1;
        if (state_q == DIV) begin
            res   = quot;
            wr_en = (b_p0 != '0);
        end else if (MADD_EN && op_p0[2]) begin
            res = {hi_q, lo_q} + prod;
        end
    end

    // Completion edge: commit HI/LO and raise the one-cycle Done.
    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= finish;
            if (finish && wr_en) begin
                hi_q <= res[2*WIDTH-1:WIDTH];
                lo_q <= res[WIDTH-1:0];
            end
            if (wr_mthi) hi_q <= bus.A;
            if (wr_mtlo) lo_q <= bus.A;
        end
    end

    assign bus.Busy = (state_q != IDLE);
    assign bus.Done = done_q;
    assign bus.HI   = hi_q;
    assign bus.LO   = lo_q;
endmodule

// File: tb/tb_mdu_unit.sv
// Directed bench for mdu_unit: vector table of MULT/DIV ops plus handshake corner sequences.
module tb_mdu_unit;
    localparam int W = 32;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    mdu_unit_if #(.WIDTH(W)) bus ();

    mdu_unit #(.WIDTH(W), .MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
        .Clk   (clk),
        .Reset (rst_n),
        .bus   (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] hi0;
        logic [31:0] lo0;
        logic [31:0] exp_hi;
        logic [31:0] exp_lo;
        int          cyc;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // All tasks start and end on a falling edge.
    task automatic start_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        bus.Start = 1'b1;
        bus.Op    = op;
        bus.A     = a;
        bus.B     = b;
        @(negedge clk);
        bus.Start = 1'b0;
    endtask

    task automatic preload(input logic [31:0] hi, input logic [31:0] lo);
        start_op(3'b100, hi, 32'h0);
        start_op(3'b101, lo, 32'h0);
    endtask

    task automatic wait_done(output int busy_n, output bit seen);
        busy_n = 0;
        seen   = 1'b0;
        for (int c = 0; c < 60; c++) begin
            if (bus.Done) begin
                seen = 1'b1;
                break;
            end
            if (bus.Busy) busy_n++;
            @(negedge clk);
        end
    endtask

    initial begin
        int bn;
        bit seen;
        bit busy_any;
        bit done_any;

        checks    = 0;
        errors    = 0;
        rst_n     = 1'b0;
        bus.Start = 1'b0;
        bus.Op    = 3'b000;
        bus.A     = '0;
        bus.B     = '0;

        vecs[0] = '{"mult_neg2x3",  3'b000, 32'hFFFFFFFE, 32'h3,        32'h0,    32'h0,    32'hFFFFFFFF, 32'hFFFFFFFA, 5};
        vecs[1] = '{"multu_max",    3'b001, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0,    32'h0,    32'hFFFFFFFE, 32'h00000001, 5};
        vecs[2] = '{"mult_7xneg3",  3'b000, 32'h7,        32'hFFFFFFFD, 32'h0,    32'h0,    32'hFFFFFFFF, 32'hFFFFFFEB, 5};
        vecs[3] = '{"multu_carry",  3'b001, 32'h00010000, 32'h00010000, 32'h0,    32'h0,    32'h00000001, 32'h00000000, 5};
        vecs[4] = '{"div_neg7_2",   3'b010, 32'hFFFFFFF9, 32'h2,        32'h0,    32'h0,    32'hFFFFFFFF, 32'hFFFFFFFD, 10};
        vecs[5] = '{"div_7_neg2",   3'b010, 32'h7,        32'hFFFFFFFE, 32'h0,    32'h0,    32'h00000001, 32'hFFFFFFFD, 10};
        vecs[6] = '{"div_min_neg1", 3'b010, 32'h80000000, 32'hFFFFFFFF, 32'h9,    32'h9,    32'h00000000, 32'h80000000, 10};
        vecs[7] = '{"divu_100_7",   3'b011, 32'd100,      32'd7,        32'h0,    32'h0,    32'h00000002, 32'h0000000E, 10};
        vecs[8] = '{"divu_by0",     3'b011, 32'd7,        32'd0,        32'hAAAA, 32'h5555, 32'h0000AAAA, 32'h00005555, 10};

        repeat (2) @(negedge clk);
        check("reset_busy", {63'h0, bus.Busy}, 64'h0);
        check("reset_done", {63'h0, bus.Done}, 64'h0);
        check("reset_hi", {32'h0, bus.HI}, 64'h0);
        check("reset_lo", {32'h0, bus.LO}, 64'h0);
        rst_n = 1'b1;
        @(negedge clk);

        // MTHI then MTLO back-to-back
        bus.Start = 1'b1;
        bus.Op    = 3'b100;
        bus.A     = 32'h1234;
        @(negedge clk);
        busy_any  = bus.Busy;
        bus.Op    = 3'b101;
        bus.A     = 32'h5678;
        @(negedge clk);
        bus.Start = 1'b0;
        busy_any  = busy_any | bus.Busy;
        check("mt_busy", {63'h0, busy_any}, 64'h0);
        check("mt_done", {63'h0, bus.Done}, 64'h0);
        check("mthi_val", {32'h0, bus.HI}, 64'h1234);
        check("mtlo_val", {32'h0, bus.LO}, 64'h5678);

        for (int i = 0; i < 9; i++) begin
            preload(vecs[i].hi0, vecs[i].lo0);
            start_op(vecs[i].op, vecs[i].a, vecs[i].b);
            bus.A = 32'hDEADBEEF;
            bus.B = 32'h0BADF00D;
            wait_done(bn, seen);
            check({vecs[i].name, "_cycles"}, 64'(bn), 64'(vecs[i].cyc));
            check({vecs[i].name, "_done"}, {63'h0, seen}, 64'h1);
            check({vecs[i].name, "_hi"}, {32'h0, bus.HI}, {32'h0, vecs[i].exp_hi});
            check({vecs[i].name, "_lo"}, {32'h0, bus.LO}, {32'h0, vecs[i].exp_lo});
        end

        // Start during Busy is ignored
        preload(32'h0, 32'h0);
        start_op(3'b000, 32'd2, 32'd3);
        check("ign_busy", {63'h0, bus.Busy}, 64'h1);
        start_op(3'b000, 32'd100, 32'd100);
        bus.A = 32'hFFFF;
        bus.B = 32'hFFFF;
        wait_done(bn, seen);
        check("ign_cycles", 64'(bn), 64'd4);
        check("ign_hi", {32'h0, bus.HI}, 64'h0);
        check("ign_lo", {32'h0, bus.LO}, 64'h6);

        // New Start in the Done cycle is accepted
        start_op(3'b001, 32'd2, 32'd2);
        wait_done(bn, seen);
        check("b2b_cycles", 64'(bn), 64'd5);
        check("b2b_lo", {32'h0, bus.LO}, 64'h4);

        // MADDU with HI=0, LO=FFFFFFFF
        preload(32'h0, 32'hFFFFFFFF);
        start_op(3'b111, 32'd1, 32'd1);
`ifdef MDU_MADD_EN
        wait_done(bn, seen);
        check("maddu_cycles", 64'(bn), 64'd5);
        check("maddu_done", {63'h0, seen}, 64'h1);
        check("maddu_hi", {32'h0, bus.HI}, 64'h1);
        check("maddu_lo", {32'h0, bus.LO}, 64'h0);
`else
        busy_any = 1'b0;
        done_any = 1'b0;
        for (int c = 0; c < 8; c++) begin
            busy_any = busy_any | bus.Busy;
            done_any = done_any | bus.Done;
            @(negedge clk);
        end
        check("maddu_nop_busy", {63'h0, busy_any}, 64'h0);
        check("maddu_nop_done", {63'h0, done_any}, 64'h0);
        check("maddu_nop_hi", {32'h0, bus.HI}, 64'h0);
        check("maddu_nop_lo", {32'h0, bus.LO}, 64'hFFFFFFFF);
`endif

        // Async reset mid-MULT with counter at 3
        preload(32'h11, 32'h22);
        start_op(3'b000, 32'd5, 32'd5);
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("rst_mid_busy", {63'h0, bus.Busy}, 64'h0);
        check("rst_mid_hi", {32'h0, bus.HI}, 64'h0);
        check("rst_mid_lo", {32'h0, bus.LO}, 64'h0);
        @(negedge clk);
        rst_n    = 1'b1;
        busy_any = 1'b0;
        done_any = 1'b0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            busy_any = busy_any | bus.Busy;
            done_any = done_any | bus.Done;
        end
        check("rst_after_done", {63'h0, done_any}, 64'h0);
        check("rst_after_busy", {63'h0, busy_any}, 64'h0);
        check("rst_after_lo", {32'h0, bus.LO}, 64'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
